// File: rtl/ccff_chain_loader.sv
// Host-side loader: serializes valid/ready bitstream words MSB-first onto a configuration chain.
// Defining CCFF_CHAIN_LOADER_READBACK_EN adds rb_data/rb_valid, which capture ccff_tail during shifting.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_WORD | word_ready high, waiting for the next bitstream word
// SHIFT     | drives one bit of the held word onto the chain per cycle
// DONE      | last bit is on the chain inputs; done pulses on the way back to IDLE
module ccff_chain_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int CHAIN_LEN  = 1024,
    parameter int CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  ccff_head,
    output logic                  config_enable,
    input  logic                  ccff_tail,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bit_count
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    ,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    localparam int                   KW       = $clog2(WORD_WIDTH);
    localparam logic [KW-1:0]        K_LAST   = KW'(WORD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CHAIN_LEN);

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  head_q, head_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic                  abort_hit;

    assign abort_hit = abort && (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        k_d      = k_q;
        head_d   = head_q;
        enable_d = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 1'b1;
        if (abort_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_d   = '0;
                        state_d = WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (word_valid) begin
                        sreg_d  = word_data;
                        k_d     = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    head_d   = sreg_q[K_LAST - k_q];
                    enable_d = 1'b1;
                    cnt_d    = cnt_inc;
                    // Reaching the chain length wins over the word boundary, dropping unused low bits.
                    if (cnt_inc == CNT_LAST) begin
                        state_d = DONE;
                    end else if (k_q == K_LAST) begin
                        state_d = WAIT_WORD;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // busy stays up through the done pulse so it falls the cycle after done.
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            k_q      <= '0;
            head_q   <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            k_q      <= k_d;
            head_q   <= head_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign word_ready    = (state_q == WAIT_WORD);
    assign ccff_head     = head_q;
    assign config_enable = enable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_count     = cnt_q;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [WORD_WIDTH-1:0] rb_sreg_q, rb_sreg_d;
    logic [WORD_WIDTH-1:0] rb_data_q, rb_data_d;
    logic [KW-1:0]         rb_idx_q, rb_idx_d;
    logic                  rb_valid_q, rb_valid_d;

    // The chain shifts on the same edge, so ccff_tail here is its previous content.
    always_comb begin
        rb_sreg_d  = rb_sreg_q;
        rb_idx_d   = rb_idx_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (abort_hit) begin
            rb_sreg_d = '0;
            rb_idx_d  = '0;
        end else if (enable_q) begin
            rb_sreg_d[K_LAST - rb_idx_q] = ccff_tail;
            if ((rb_idx_q == K_LAST) || (cnt_q == CNT_LAST)) begin
                rb_data_d  = rb_sreg_d;
                rb_valid_d = 1'b1;
                rb_sreg_d  = '0;
                rb_idx_d   = '0;
            end else begin
                rb_idx_d = rb_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            rb_sreg_q  <= '0;
            rb_data_q  <= '0;
            rb_idx_q   <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_sreg_q  <= rb_sreg_d;
            rb_data_q  <= rb_data_d;
            rb_idx_q   <= rb_idx_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: an 8-bit chain instance with a behavioural flop chain and a 6-bit truncating instance.
// Head bits and readback words are scoreboarded through queues and checked as the DUT produces them.
module tb_ccff_chain_loader;
    localparam int W = 4;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic         pReset, abort, word_valid, start8, start6;
    logic [W-1:0] word_data;
    logic         ready8, head8, en8, busy8, done8, tail8;
    logic         ready6, head6, en6, busy6, done6, tail6;
    logic [3:0]   cnt8;
    logic [2:0]   cnt6;
    logic [7:0]   chain8, preload_val;
    logic         preload;

    int tests_run    = 0;
    int tests_failed = 0;
    int en_cnt8      = 0;
    int en_cnt6      = 0;
    int done_cnt8    = 0;
    logic         q8[$];
    logic         q6[$];
    logic [W-1:0] rbq[$];

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [W-1:0] rb8_data, rb6_data_unused;
    logic         rb8_valid, rb6_valid_unused;
`endif

    ccff_chain_loader #(.WORD_WIDTH(W), .CHAIN_LEN(8)) u_dut8 (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start8),
        .abort         (abort),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (ready8),
        .ccff_head     (head8),
        .config_enable (en8),
        .ccff_tail     (tail8),
        .busy          (busy8),
        .done          (done8),
        .bit_count     (cnt8)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        ,
        .rb_data       (rb8_data),
        .rb_valid      (rb8_valid)
`endif
    );

    ccff_chain_loader #(.WORD_WIDTH(W), .CHAIN_LEN(6)) u_dut6 (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start6),
        .abort         (abort),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (ready6),
        .ccff_head     (head6),
        .config_enable (en6),
        .ccff_tail     (tail6),
        .busy          (busy6),
        .done          (done6),
        .bit_count     (cnt6)
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        ,
        .rb_data       (rb6_data_unused),
        .rb_valid      (rb6_valid_unused)
`endif
    );

    // Behavioural 8-flop configuration chain behind the 8-bit instance.
    always @(posedge prog_clk) begin
        if (preload)  chain8 <= preload_val;
        else if (en8) chain8 <= {chain8[6:0], head8};
    end
    assign tail8 = chain8[7];
    assign tail6 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge prog_clk) begin
        logic e8, e6;
        if (en8) begin
            en_cnt8++;
            e8 = (q8.size() != 0) ? q8.pop_front() : 1'bx;
            check("head8", {31'd0, head8}, {31'd0, e8});
        end
        if (en6) begin
            en_cnt6++;
            e6 = (q6.size() != 0) ? q6.pop_front() : 1'bx;
            check("head6", {31'd0, head6}, {31'd0, e6});
        end
        if (done8) done_cnt8++;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        if (rb8_valid) begin
            logic [W-1:0] er;
            er = (rbq.size() != 0) ? rbq.pop_front() : 'x;
            check("rb_data", {28'd0, rb8_data}, {28'd0, er});
        end
`endif
    end

    task automatic pulse_start(input bit sel);
        if (sel) start6 = 1'b1;
        else     start8 = 1'b1;
        @(negedge prog_clk);
        start6 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [W-1:0] w);
        logic rdy;
        bit   ok;
        ok = 0;
        word_data  = w;
        word_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rdy = sel ? ready6 : ready8;
            @(negedge prog_clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        check("handshake", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input bit sel);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge prog_clk);
            if (sel ? done6 : done8) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_count8(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (cnt8 == n[3:0]) begin
                ok = 1;
                break;
            end
            @(negedge prog_clk);
        end
        check("count_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic load8(input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [7:0] pre, input int gap);
        int  e0, d0;
        bit  ok;
        preload_val = pre;
        preload     = 1'b1;
        @(negedge prog_clk);
        preload = 1'b0;
        for (int i = W - 1; i >= 0; i--) q8.push_back(w0[i]);
        for (int i = W - 1; i >= 0; i--) q8.push_back(w1[i]);
        rbq.push_back(pre[7:4]);
        rbq.push_back(pre[3:0]);
        e0 = en_cnt8;
        d0 = done_cnt8;
        pulse_start(0);
        check("start_count_clear", {28'd0, cnt8}, 32'd0);
        check("start_busy", {31'd0, busy8}, 32'd1);
        send_word(0, w0);
        if (gap > 0) begin
            word_valid = 1'b0;
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge prog_clk);
                if (ready8) begin
                    ok = 1;
                    break;
                end
            end
            check("stall_ready_seen", {31'd0, ok}, 32'd1);
            repeat (gap) begin
                @(negedge prog_clk);
                check("stall_ready", {31'd0, ready8}, 32'd1);
                check("stall_enable", {31'd0, en8}, 32'd0);
            end
        end
        send_word(0, w1);
        word_valid = 1'b0;
        wait_done(0);
        check("busy_at_done", {31'd0, busy8}, 32'd1);
        check("bit_count_8", {28'd0, cnt8}, 32'd8);
        @(negedge prog_clk);
        check("busy_after_done", {31'd0, busy8}, 32'd0);
        check("done_one_cycle", {31'd0, done8}, 32'd0);
        check("enable_cycles", en_cnt8 - e0, 32'd8);
        check("done_pulses", done_cnt8 - d0, 32'd1);
        check("chain_content", {24'd0, chain8}, {24'd0, w0, w1});
        check("head_queue_empty", q8.size(), 32'd0);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        check("rb_queue_empty", rbq.size(), 32'd0);
`endif
    endtask

    initial begin
        int d0;
        pReset      = 1'b1;
        abort       = 1'b0;
        start8      = 1'b0;
        start6      = 1'b0;
        word_valid  = 1'b0;
        word_data   = '0;
        preload     = 1'b0;
        preload_val = '0;
        repeat (3) @(negedge prog_clk);

        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_ready", {31'd0, ready8}, 32'd0);
        check("rst_head", {31'd0, head8}, 32'd0);
        check("rst_enable", {31'd0, en8}, 32'd0);
        check("rst_count", {28'd0, cnt8}, 32'd0);
        check("rst_busy6", {31'd0, busy6}, 32'd0);
        pReset = 1'b0;
        @(negedge prog_clk);

        // Basic load, then the same words across a stall.
        load8(4'hA, 4'h5, 8'h00, 0);
        load8(4'hA, 4'h5, 8'h5A, 5);

        // Truncation on the 6-bit chain: the last two bits of 4'h3 are dropped.
        for (int i = 3; i >= 0; i--) q6.push_back(1'b1);
        q6.push_back(1'b0);
        q6.push_back(1'b0);
        pulse_start(1);
        send_word(1, 4'hF);
        send_word(1, 4'h3);
        word_valid = 1'b0;
        wait_done(1);
        check("trunc_count", {29'd0, cnt6}, 32'd6);
        @(negedge prog_clk);
        check("trunc_enables", en_cnt6, 32'd6);
        check("trunc_queue_empty", q6.size(), 32'd0);
        check("trunc_idle_ready", {31'd0, ready6}, 32'd0);
        check("trunc_idle_busy", {31'd0, busy6}, 32'd0);

        // Abort after three bits of the first word.
        for (int i = 3; i >= 0; i--) q8.push_back(i[0] ? 1'b1 : 1'b0);
        pulse_start(0);
        send_word(0, 4'hA);
        word_valid = 1'b0;
        wait_count8(3);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_enable", {31'd0, en8}, 32'd0);
        check("abort_count", {28'd0, cnt8}, 32'd3);
        q8.delete();
        d0 = done_cnt8;
        repeat (3) @(negedge prog_clk);
        check("abort_no_done", done_cnt8 - d0, 32'd0);
        check("abort_count_hold", {28'd0, cnt8}, 32'd3);
        load8(4'h5, 4'hA, 8'hFF, 0);

        // Reset in the middle of SHIFT, with start held high alongside it.
        for (int i = 3; i >= 0; i--) q8.push_back(i >= 2 ? 1'b1 : 1'b0);
        pulse_start(0);
        send_word(0, 4'hC);
        word_valid = 1'b0;
        wait_count8(2);
        pReset = 1'b1;
        start8 = 1'b1;
        @(negedge prog_clk);
        check("mid_rst_busy", {31'd0, busy8}, 32'd0);
        check("mid_rst_head", {31'd0, head8}, 32'd0);
        check("mid_rst_enable", {31'd0, en8}, 32'd0);
        check("mid_rst_count", {28'd0, cnt8}, 32'd0);
        check("mid_rst_ready", {31'd0, ready8}, 32'd0);
        check("mid_rst_done", {31'd0, done8}, 32'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        start8 = 1'b0;
        @(negedge prog_clk);
        check("rst_start_ignored", {31'd0, busy8}, 32'd0);
        q8.delete();

        // Chain preloaded with 8'hC3 reads back as 4'hC then 4'h3 while 8'h3C goes in.
        load8(4'h3, 4'hC, 8'hC3, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
